// File: rtl/id_ex_stage_if.sv
// ID/EX stage bus interface.
// Bundles everything the ID/EX stage exchanges with the rest of the pipeline:
//   id_*   : decoded instruction and register-file read data from ID
//   flush  : branch/jump redirect, kills the ID instruction
//   mem_*  : destination/result of the instruction in MEM (forwarding source)
//   wb_*   : destination/data being written back this cycle (forwarding source)
//   stall  : load-use hold request for PC and IF/ID
//   ex_*   : ALU-facing outputs of the EX stage
// Modport slave is the stage itself; master is the surrounding pipeline.
interface id_ex_stage_if #(
  parameter int unsigned XLEN = 32
);
  logic            id_valid;
  logic [XLEN-1:0] id_pc;
  logic [4:0]      id_opcode;
  logic [2:0]      id_func3;
  logic            id_func7;
  logic [4:0]      id_rs1;
  logic [4:0]      id_rs2;
  logic [4:0]      id_rd;
  logic [XLEN-1:0] id_rs1_data;
  logic [XLEN-1:0] id_rs2_data;
  logic [XLEN-1:0] id_imm;
  logic            flush;
  logic [4:0]      mem_rd;
  logic [XLEN-1:0] mem_data;
  logic [4:0]      wb_rd;
  logic [XLEN-1:0] wb_data;
  logic            stall;
  logic            ex_valid;
  logic [4:0]      ex_opcode;
  logic [2:0]      ex_func3;
  logic            ex_func7;
  logic [4:0]      ex_rd;
  logic [XLEN-1:0] ex_operand1;
  logic [XLEN-1:0] ex_operand2;
  logic [XLEN-1:0] ex_store_data;

  modport slave (
    input  id_valid, id_pc, id_opcode, id_func3, id_func7,
           id_rs1, id_rs2, id_rd, id_rs1_data, id_rs2_data, id_imm,
           flush, mem_rd, mem_data, wb_rd, wb_data,
    output stall, ex_valid, ex_opcode, ex_func3, ex_func7, ex_rd,
           ex_operand1, ex_operand2, ex_store_data
  );

  modport master (
    output id_valid, id_pc, id_opcode, id_func3, id_func7,
           id_rs1, id_rs2, id_rd, id_rs1_data, id_rs2_data, id_imm,
           flush, mem_rd, mem_data, wb_rd, wb_data,
    input  stall, ex_valid, ex_opcode, ex_func3, ex_func7, ex_rd,
           ex_operand1, ex_operand2, ex_store_data
  );
endinterface

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register and EX-stage operand selector feeding the ALU.
// Ports:
//   clk : pipeline clock, state updates on the rising edge
//   rst : asynchronous active-high reset, clears EX to a bubble
//   bus : id_ex_stage_if.slave -- ID inputs, flush, MEM/WB forwarding
//         sources in; stall and ALU-facing EX outputs out
// Behaviour summary:
//   - ID capture bypasses a same-cycle WB write into the latched rs values.
//   - EX forwards MEM (higher priority) then WB onto the latched rs values;
//     x0 is never forwarded.
//   - A load in EX whose rd is read by the ID instruction raises stall and a
//     bubble is loaded; flush overrides stall and also loads a bubble.
module id_ex_stage #(
  parameter int unsigned XLEN = 32
) (
  input logic         clk,
  input logic         rst,
  id_ex_stage_if.slave bus
);

  typedef enum logic [4:0] {
    OP_LOAD   = 5'b00000,
    OP_IMM    = 5'b00100,
    OP_AUIPC  = 5'b00101,
    OP_STORE  = 5'b01000,
    OP_REG    = 5'b01100,
    OP_LUI    = 5'b01101,
    OP_BRANCH = 5'b11000,
    OP_JALR   = 5'b11001,
    OP_JAL    = 5'b11011
  } opcode_e;

  // EX-stage state
  logic            r_valid;
  logic [4:0]      r_opcode;
  logic [4:0]      r_rd;
  logic [XLEN-1:0] r_pc;
  logic [2:0]      r_func3;
  logic            r_func7;
  logic [4:0]      r_rs1;
  logic [4:0]      r_rs2;
  logic [XLEN-1:0] r_rs1_val;
  logic [XLEN-1:0] r_rs2_val;
  logic [XLEN-1:0] r_imm;

  // ID-side decode and bypass
  logic            w_id_uses_rs1;
  logic            w_id_uses_rs2;
  logic [XLEN-1:0] w_id_rs1_val;
  logic [XLEN-1:0] w_id_rs2_val;

  // Hazard detection
  logic            w_load_in_ex;
  logic            w_rs_match;
  logic            w_stall;
  logic            w_bubble;

  // EX-side forwarding and operand selection
  logic [XLEN-1:0] w_fwd_rs1;
  logic [XLEN-1:0] w_fwd_rs2;
  logic            w_op1_is_pc;
  logic            w_op2_is_rs2;

  always_comb begin
    w_id_uses_rs1 = !((bus.id_opcode == OP_LUI)   ||
                      (bus.id_opcode == OP_AUIPC) ||
                      (bus.id_opcode == OP_JAL));
    w_id_uses_rs2 = (bus.id_opcode == OP_REG)   ||
                    (bus.id_opcode == OP_STORE) ||
                    (bus.id_opcode == OP_BRANCH);
  end

  // The register file is written at the same edge we capture, so its read
  // data is stale for a register being written back right now.
  always_comb begin
    w_id_rs1_val = bus.id_rs1_data;
    w_id_rs2_val = bus.id_rs2_data;
    if ((bus.wb_rd != '0) && (bus.wb_rd == bus.id_rs1)) begin
      w_id_rs1_val = bus.wb_data;
    end
    if ((bus.wb_rd != '0) && (bus.wb_rd == bus.id_rs2)) begin
      w_id_rs2_val = bus.wb_data;
    end
  end

  // Load data only appears in WB, so a consumer directly behind a load must
  // wait one cycle; after the bubble it picks the value up via WB forwarding.
  always_comb begin
    w_load_in_ex = r_valid && (r_opcode == OP_LOAD) && (r_rd != '0);
    w_rs_match   = (w_id_uses_rs1 && (bus.id_rs1 == r_rd)) ||
                   (w_id_uses_rs2 && (bus.id_rs2 == r_rd));
    w_stall      = w_load_in_ex && bus.id_valid && w_rs_match && !bus.flush;
    w_bubble     = bus.flush || w_stall;
  end

  // Control state: valid/opcode/rd decide whether EX holds an instruction.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_valid  <= 1'b0;
      r_opcode <= '0;
      r_rd     <= '0;
    end else if (w_bubble) begin
      r_valid  <= 1'b0;
      r_opcode <= '0;
      r_rd     <= '0;
    end else begin
      r_valid  <= bus.id_valid;
      r_opcode <= bus.id_valid ? bus.id_opcode : '0;
      r_rd     <= bus.id_valid ? bus.id_rd     : '0;
    end
  end

  // Payload state is don't-care while EX holds a bubble, so it simply
  // follows ID every cycle instead of being gated by the bubble decision.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_pc      <= '0;
      r_func3   <= '0;
      r_func7   <= 1'b0;
      r_rs1     <= '0;
      r_rs2     <= '0;
      r_rs1_val <= '0;
      r_rs2_val <= '0;
      r_imm     <= '0;
    end else begin
      r_pc      <= bus.id_pc;
      r_func3   <= bus.id_func3;
      r_func7   <= bus.id_func7;
      r_rs1     <= bus.id_rs1;
      r_rs2     <= bus.id_rs2;
      r_rs1_val <= w_id_rs1_val;
      r_rs2_val <= w_id_rs2_val;
      r_imm     <= bus.id_imm;
    end
  end

  // MEM holds the younger result, so it wins over WB.
  always_comb begin
    if ((bus.mem_rd != '0) && (bus.mem_rd == r_rs1)) begin
      w_fwd_rs1 = bus.mem_data;
    end else if ((bus.wb_rd != '0) && (bus.wb_rd == r_rs1)) begin
      w_fwd_rs1 = bus.wb_data;
    end else begin
      w_fwd_rs1 = r_rs1_val;
    end

    if ((bus.mem_rd != '0) && (bus.mem_rd == r_rs2)) begin
      w_fwd_rs2 = bus.mem_data;
    end else if ((bus.wb_rd != '0) && (bus.wb_rd == r_rs2)) begin
      w_fwd_rs2 = bus.wb_data;
    end else begin
      w_fwd_rs2 = r_rs2_val;
    end
  end

  always_comb begin
    w_op1_is_pc  = (r_opcode == OP_AUIPC) ||
                   (r_opcode == OP_JAL)   ||
                   (r_opcode == OP_JALR);
    w_op2_is_rs2 = (r_opcode == OP_REG) || (r_opcode == OP_BRANCH);
  end

  always_comb begin
    bus.stall         = w_stall;
    bus.ex_valid      = r_valid;
    bus.ex_opcode     = r_opcode;
    bus.ex_func3      = r_func3;
    bus.ex_func7      = r_func7;
    bus.ex_rd         = r_rd;
    bus.ex_operand1   = w_op1_is_pc  ? r_pc      : w_fwd_rs1;
    bus.ex_operand2   = w_op2_is_rs2 ? w_fwd_rs2 : r_imm;
    bus.ex_store_data = w_fwd_rs2;
  end

endmodule

// File: tb/tb_id_ex_stage.sv
module tb_id_ex_stage;
  localparam int XLEN = 32;

  localparam logic [4:0] LOAD  = 5'b00000;
  localparam logic [4:0] IMM   = 5'b00100;
  localparam logic [4:0] AUIPC = 5'b00101;
  localparam logic [4:0] REG   = 5'b01100;
  localparam logic [4:0] LUI   = 5'b01101;
  localparam logic [4:0] BR    = 5'b11000;
  localparam logic [4:0] JALR  = 5'b11001;
  localparam logic [4:0] JAL   = 5'b11011;
  localparam logic [4:0] STORE = 5'b01000;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  id_ex_stage_if #(.XLEN(XLEN)) bus ();
  id_ex_stage #(.XLEN(XLEN)) dut (.clk(clk), .rst(rst), .bus(bus));

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // The model remembers which instruction occupies EX (or that it is empty)
  // and derives every ALU-facing value from the architectural rules.
  typedef struct packed {
    logic        valid;
    logic [31:0] pc;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] imm;
    logic [4:0]  op;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
    logic [2:0]  f3;
    logic        f7;
  } ex_t;

  ex_t m = '0;

  function automatic bit reads_rs1(input logic [4:0] op);
    return !(op == LUI || op == AUIPC || op == JAL);
  endfunction

  function automatic bit reads_rs2(input logic [4:0] op);
    return op == REG || op == STORE || op == BR;
  endfunction

  function automatic bit model_stall();
    bit dep;
    if (!(m.valid && m.op == LOAD && m.rd != 0 && bus.id_valid)) return 0;
    if (bus.flush) return 0;
    dep = (reads_rs1(bus.id_opcode) && bus.id_rs1 == m.rd) ||
          (reads_rs2(bus.id_opcode) && bus.id_rs2 == m.rd);
    return dep;
  endfunction

  // Architectural value of register r as seen in EX right now.
  function automatic logic [31:0] reg_value(input logic [4:0] r, input logic [31:0] latched);
    if (r == 0) return latched;
    if (r == bus.mem_rd) return bus.mem_data;
    if (r == bus.wb_rd) return bus.wb_data;
    return latched;
  endfunction

  always @(posedge clk or posedge rst) begin : model_update
    ex_t n;
    if (rst) begin
      m = '0;
    end else if (bus.flush || model_stall()) begin
      m.valid = 0; m.op = 0; m.rd = 0;
    end else begin
      n = '0;
      n.valid = bus.id_valid;
      n.op    = bus.id_valid ? bus.id_opcode : 5'd0;
      n.rd    = bus.id_valid ? bus.id_rd : 5'd0;
      n.pc    = bus.id_pc;
      n.f3    = bus.id_func3;
      n.f7    = bus.id_func7;
      n.rs1   = bus.id_rs1;
      n.rs2   = bus.id_rs2;
      n.imm   = bus.id_imm;
      n.a     = (bus.id_rs1 != 0 && bus.id_rs1 == bus.wb_rd) ? bus.wb_data : bus.id_rs1_data;
      n.b     = (bus.id_rs2 != 0 && bus.id_rs2 == bus.wb_rd) ? bus.wb_data : bus.id_rs2_data;
      m = n;
    end
  end

  always @(negedge clk) begin : compare
    logic [31:0] e1, e2;
    if (!rst) begin
      chk("stall", bus.stall, model_stall());
      chk("ex_valid", bus.ex_valid, m.valid);
      chk("ex_opcode", bus.ex_opcode, m.op);
      chk("ex_rd", bus.ex_rd, m.rd);
      if (m.valid) begin
        e1 = (m.op == AUIPC || m.op == JAL || m.op == JALR) ? m.pc : reg_value(m.rs1, m.a);
        e2 = (m.op == REG || m.op == BR) ? reg_value(m.rs2, m.b) : m.imm;
        chk("ex_func3", bus.ex_func3, m.f3);
        chk("ex_func7", bus.ex_func7, m.f7);
        chk("ex_operand1", bus.ex_operand1, e1);
        chk("ex_operand2", bus.ex_operand2, e2);
        chk("ex_store_data", bus.ex_store_data, reg_value(m.rs2, m.b));
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic idle();
    bus.id_valid = 0; bus.id_pc = 0; bus.id_opcode = 0; bus.id_func3 = 0;
    bus.id_func7 = 0; bus.id_rs1 = 0; bus.id_rs2 = 0; bus.id_rd = 0;
    bus.id_rs1_data = 0; bus.id_rs2_data = 0; bus.id_imm = 0; bus.flush = 0;
    bus.mem_rd = 0; bus.mem_data = 0; bus.wb_rd = 0; bus.wb_data = 0;
  endtask

  task automatic issue(input logic [4:0] op, input logic [4:0] rs1, input logic [4:0] rs2,
                       input logic [4:0] rd, input logic [31:0] d1, input logic [31:0] d2,
                       input logic [31:0] imm, input logic [31:0] pc);
    bus.id_valid = 1; bus.id_opcode = op; bus.id_rs1 = rs1; bus.id_rs2 = rs2;
    bus.id_rd = rd; bus.id_rs1_data = d1; bus.id_rs2_data = d2; bus.id_imm = imm;
    bus.id_pc = pc; bus.id_func3 = rd[2:0]; bus.id_func7 = rs2[0];
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    idle();
    rst = 1;
    #12;
    chk("rst_valid", bus.ex_valid, 0);
    chk("rst_opcode", bus.ex_opcode, 0);
    chk("rst_rd", bus.ex_rd, 0);
    chk("rst_stall", bus.stall, 0);
    rst = 0;
    tick();

    // addi x5,x0,7
    issue(IMM, 0, 7, 5, 0, 32'h123, 7, 32'h10);
    tick(); idle(); #1;
    chk("addi_op1", bus.ex_operand1, 0);
    chk("addi_op2", bus.ex_operand2, 7);
    chk("addi_valid", bus.ex_valid, 1);
    chk("addi_stall", bus.stall, 0);

    // add x3,x1,x2: MEM beats WB on x1, WB supplies x2
    issue(REG, 1, 2, 3, 32'h111, 32'h222, 0, 32'h14);
    tick(); idle();
    bus.mem_rd = 1; bus.mem_data = 32'h10; bus.wb_rd = 1; bus.wb_data = 32'h20; #1;
    chk("fwd_mem_wins", bus.ex_operand1, 32'h10);
    bus.wb_rd = 2; bus.wb_data = 32'h5; #1;
    chk("fwd_wb_op2", bus.ex_operand2, 32'h5);
    chk("fwd_wb_store", bus.ex_store_data, 32'h5);
    chk("fwd_op1_hold", bus.ex_operand1, 32'h10);

    // ID-side bypass of a same-cycle write-back
    issue(REG, 1, 2, 3, 32'h111, 32'h222, 0, 32'h18);
    bus.mem_rd = 0; bus.wb_rd = 2; bus.wb_data = 32'h77;
    tick(); idle(); #1;
    chk("id_bypass_op2", bus.ex_operand2, 32'h77);
    chk("id_bypass_op1", bus.ex_operand1, 32'h111);

    // lw x4 then add x6,x4,x4
    issue(LOAD, 1, 0, 4, 32'h1000, 0, 0, 32'h20);
    tick();
    issue(REG, 4, 4, 6, 32'h9999, 32'h9999, 0, 32'h24); #1;
    chk("lu_stall", bus.stall, 1);
    tick();
    bus.mem_rd = 4; bus.mem_data = 32'h1000; #1;
    chk("lu_bubble_valid", bus.ex_valid, 0);
    chk("lu_bubble_rd", bus.ex_rd, 0);
    chk("lu_stall_once", bus.stall, 0);
    tick(); idle();
    bus.wb_rd = 4; bus.wb_data = 32'hABCD; #1;
    chk("lu_op1", bus.ex_operand1, 32'hABCD);
    chk("lu_op2", bus.ex_operand2, 32'hABCD);
    chk("lu_rd", bus.ex_rd, 6);

    // independent after load; LUI whose rs1 bits happen to match
    issue(LOAD, 1, 0, 7, 32'h40, 0, 4, 32'h30);
    tick(); idle();
    issue(REG, 1, 2, 8, 1, 2, 0, 32'h34); #1;
    chk("indep_no_stall", bus.stall, 0);
    issue(LUI, 7, 7, 9, 0, 0, 32'h7000, 32'h34); #1;
    chk("lui_no_stall", bus.stall, 0);
    issue(IMM, 7, 3, 9, 0, 0, 3, 32'h34); #1;
    chk("imm_stall", bus.stall, 1);
    tick(); tick(); idle(); tick();

    // chained loads stall once per dependent pair
    issue(LOAD, 1, 0, 10, 32'h80, 0, 0, 32'h40);
    tick();
    issue(LOAD, 10, 0, 11, 0, 0, 0, 32'h44); #1;
    chk("chain1_stall", bus.stall, 1);
    tick(); #1;
    chk("chain1_once", bus.stall, 0);
    tick();
    issue(LOAD, 11, 0, 12, 0, 0, 0, 32'h48); #1;
    chk("chain2_stall", bus.stall, 1);
    tick(); idle(); tick();

    // load to x0 never stalls
    issue(LOAD, 1, 0, 0, 32'h80, 0, 0, 32'h50);
    tick();
    issue(REG, 0, 0, 3, 0, 0, 0, 32'h54); #1;
    chk("x0_load_no_stall", bus.stall, 0);
    tick(); idle(); tick();

    // flush overrides load-use
    issue(LOAD, 1, 0, 4, 32'h100, 0, 0, 32'h60);
    tick();
    issue(REG, 4, 4, 6, 0, 0, 0, 32'h64);
    bus.flush = 1; #1;
    chk("flush_stall", bus.stall, 0);
    tick(); idle(); #1;
    chk("flush_valid", bus.ex_valid, 0);
    chk("flush_rd", bus.ex_rd, 0);

    // auipc and jal take the PC
    issue(AUIPC, 0, 0, 5, 0, 0, 32'h2000, 32'h100);
    tick(); idle(); #1;
    chk("auipc_op1", bus.ex_operand1, 32'h100);
    chk("auipc_op2", bus.ex_operand2, 32'h2000);
    issue(JAL, 3, 4, 1, 32'h55, 32'h66, 32'h80, 32'h40);
    tick(); idle(); #1;
    chk("jal_op1", bus.ex_operand1, 32'h40);
    chk("jal_op2", bus.ex_operand2, 32'h80);

    // add x1,x0,x0 never forwards into x0
    issue(REG, 0, 0, 1, 0, 0, 0, 32'h70);
    tick(); idle();
    bus.mem_rd = 0; bus.mem_data = 32'hFFFF; bus.wb_rd = 0; bus.wb_data = 32'hEEEE; #1;
    chk("x0_op1", bus.ex_operand1, 0);
    chk("x0_op2", bus.ex_operand2, 0);

    // reset mid-stall acts without a clock edge
    idle();
    issue(LOAD, 1, 0, 4, 32'h200, 0, 0, 32'h80);
    tick();
    issue(REG, 4, 0, 6, 0, 0, 0, 32'h84); #1;
    chk("pre_rst_stall", bus.stall, 1);
    rst = 1; #1;
    chk("rst_async_valid", bus.ex_valid, 0);
    chk("rst_async_stall", bus.stall, 0);
    rst = 0;
    tick(); idle(); tick(); tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/id_ex_stage.md
Name: id_ex_stage

Overview:
ID/EX pipeline register and EX-stage operand selector directly upstream of the ALU. Captures the decoded instruction from ID and bypasses same-cycle register-file writes. In EX it forwards results from MEM/WB and drives the ALU's opcode, func3, func7, operand1 and operand2. Detects load-use hazards, stalls IF/ID and inserts bubbles. Honours branch/jump flush.

Parameters:
XLEN, 32, datapath width; operands, PC, immediates and forwarded data are all XLEN bits.

Ports:
clk  in  1  pipeline clock; all state updates on the rising edge
rst  in  1  reset, asynchronous, active-high
id_valid  in  1  ID holds a real instruction
id_pc  in  XLEN  PC of the ID instruction
id_opcode  in  5  instr[6:2]
id_func3  in  3  instr[14:12]
id_func7  in  1  instr[30]
id_rs1  in  5  source register 1 address
id_rs2  in  5  source register 2 address
id_rd  in  5  destination; 0 for non-writing instructions
id_rs1_data  in  XLEN  register file read data for rs1
id_rs2_data  in  XLEN  register file read data for rs2
id_imm  in  XLEN  sign-extended/shifted immediate
flush  in  1  branch/jump redirect; kill the ID instruction
mem_rd  in  5  rd of the instruction in MEM; 0 means no write
mem_data  in  XLEN  ALU result held in EX/MEM
wb_rd  in  5  rd being written back this cycle; 0 means no write
wb_data  in  XLEN  write-back data
stall  out  1  hold PC and IF/ID this cycle (combinational)
ex_valid  out  1  EX holds a real instruction
ex_opcode  out  5  to ALU opcode; 0 when the stage holds a bubble
ex_func3  out  3  to ALU func3
ex_func7  out  1  to ALU func7
ex_rd  out  5  destination passed toward EX/MEM; 0 for a bubble
ex_operand1  out  XLEN  to ALU operand1 (combinational from EX state)
ex_operand2  out  XLEN  to ALU operand2 (combinational from EX state)
ex_store_data  out  XLEN  forwarded rs2 value for stores

Behaviour:
- Reset (asynchronous): all EX registers cleared; ex_valid=0, ex_opcode=0, ex_rd=0. The outputs then equal those of a bubble. Reset asserted mid-stall aborts the stall.
- Opcode classes: R=01100, I_Comp=00100, Load=00000, Store=01000, B=11000, JAL=11011, JALR=11001, LUI=01101, AUIPC=00101.
- uses_rs1 is true for all classes except LUI, AUIPC and JAL. uses_rs2 is true for R, Store and B only.
- ID-side capture bypass: if wb_rd!=0 and wb_rd==id_rs1, latch wb_data instead of id_rs1_data. Same rule for rs2.
- Load-use stall: stall=1 when all of the following hold:
  - ex_valid is set and ex_opcode==Load and ex_rd!=0;
  - id_valid is set;
  - (uses_rs1 and id_rs1==ex_rd) or (uses_rs2 and id_rs2==ex_rd).
  flush=1 forces stall=0.
- Edge update, in priority order:
  1. rst.
  2. flush or stall: load a bubble (ex_valid=0, opcode=0, rd=0).
  3. Otherwise capture the ID fields, with ex_valid=id_valid. When id_valid=0, opcode and rd are also zeroed.
- EX forwarding of the latched rs1 and rs2 values (src = rs1 or rs2):
  - If mem_rd!=0 and mem_rd==src, use mem_data.
  - Else if wb_rd!=0 and wb_rd==src, use wb_data.
  - Else use the latched value.
  - MEM has priority over WB. x0 is never forwarded. Register address 0 always yields the latched value, which is 0 from the register file.
- ex_operand1 selection:
  - latched PC for AUIPC, JAL and JALR;
  - forwarded rs1 otherwise.
- ex_operand2 selection:
  - forwarded rs2 for R and B;
  - latched immediate for all other classes.
- ex_store_data is always the forwarded rs2.
- Latency:
  - One cycle from ID capture to EX outputs.
  - A stall costs exactly one bubble. In the following cycle the load sits in WB, and the consumer takes the value through WB forwarding.
- Consecutive loads feeding each other stall once per dependent pair. An independent instruction after a load must not stall.

Test Plan:
- addi x5,x0,7 (I_Comp, imm=7), no hazards -> next cycle ex_operand1=0, ex_operand2=7, ex_valid=1, stall=0.
- add x3,x1,x2 with mem_rd=1/mem_data=0x10 and wb_rd=1/wb_data=0x20, wb_rd=2/wb_data=0x5 -> ex_operand1=0x10 (MEM wins), ex_operand2=0x5.
- lw x4 in EX, then add x6,x4,x4 in ID -> stall=1 for exactly one cycle and a bubble enters EX. Next cycle wb_rd=4, wb_data=0xABCD -> ex_operand1=ex_operand2=0xABCD.
- Load-use condition present and flush=1 in the same cycle -> stall=0, EX holds a bubble (ex_valid=0, ex_rd=0).
- auipc with id_pc=0x100, imm=0x2000 -> ex_operand1=0x100, ex_operand2=0x2000. jal at pc 0x40 -> ex_operand1=0x40.
- add x1,x0,x0 with mem_rd=0/mem_data=0xFFFF -> both operands 0. Assert rst mid-stall -> ex_valid=0 and stall=0 immediately, without waiting for a clock edge.
